// File: rtl/m_p_to_s_tx.sv
// Parallel-to-serial transmitter: FIFO-buffered words sent as start pulse + MSB-first bits.
// Optional macro P_TO_S_PARITY_EN appends an even-parity bit after the data bits.
module m_p_to_s_tx #(
    parameter int WORD  = 8,
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WORD-1:0]            in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       start,
    output logic                       serial_d,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WORD + 1);
    localparam int GW = $clog2(GAP + 1);

`ifdef P_TO_S_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_PARITY, S_GAP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_GAP} state_t;
`endif

    state_t          state, state_n;
    logic [WORD-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_n;
    logic [WORD-1:0] sr, sr_n;
    logic [BW-1:0]   bit_cnt, bit_n;
    logic [GW-1:0]   gap_cnt, gap_n;
    logic            push, pop;
    logic            start_n, serial_n, busy_n, done_n;
`ifdef P_TO_S_PARITY_EN
    logic            par;
`endif

    assign in_ready   = (count != CW'(DEPTH));
    assign fifo_count = count;

    always_comb begin
        push     = in_valid && in_ready;
        pop      = (state == S_IDLE) && (count != '0);
        count_n  = count + CW'(push) - CW'(pop);
        state_n  = state;
        sr_n     = sr;
        bit_n    = bit_cnt;
        gap_n    = gap_cnt;
        start_n  = 1'b0;
        serial_n = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        // Outputs are computed for the next state so that they are registered.
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_n = S_START;
                    sr_n    = mem[rd_ptr];
                    bit_n   = '0;
                    start_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            S_START: begin
                state_n  = S_SHIFT;
                serial_n = sr[WORD-1];
                sr_n     = sr << 1;
                busy_n   = 1'b1;
            end
            S_SHIFT: begin
                busy_n = 1'b1;
                if (bit_cnt == BW'(WORD - 1)) begin
`ifdef P_TO_S_PARITY_EN
                    state_n  = S_PARITY;
                    serial_n = par;
`else
                    state_n  = S_GAP;
                    gap_n    = '0;
                    done_n   = 1'b1;
`endif
                end else begin
                    bit_n    = bit_cnt + 1'b1;
                    serial_n = sr[WORD-1];
                    sr_n     = sr << 1;
                end
            end
`ifdef P_TO_S_PARITY_EN
            S_PARITY: begin
                state_n = S_GAP;
                gap_n   = '0;
                done_n  = 1'b1;
                busy_n  = 1'b1;
            end
`endif
            S_GAP: begin
                if (gap_cnt == GW'(GAP - 1)) begin
                    state_n = S_IDLE;
                end else begin
                    gap_n  = gap_cnt + 1'b1;
                    busy_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            sr       <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            start    <= 1'b0;
            serial_d <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            sr       <= sr_n;
            bit_cnt  <= bit_n;
            gap_cnt  <= gap_n;
            start    <= start_n;
            serial_d <= serial_n;
            busy     <= busy_n;
            done     <= done_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef P_TO_S_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    par <= 1'b0;
        else if (pop) par <= ^mem[rd_ptr];
    end
`endif

endmodule

// File: doc/m_p_to_s_tx.md
# m_p_to_s_tx

Parallel-to-serial transmitter that sits directly upstream of the MPU serial-to-parallel receiver. It accepts WORD-bit words over a valid/ready handshake into a small FIFO. It then emits each word as a one-cycle `start` pulse followed by WORD serial bits, MSB first, on `serial_d`. This ordering matches the receiver's left-shifting assembly, so the first bit sent lands in the receiver's MSB.

## Interface
- `WORD`, 8: data word width; serial frame carries WORD data bits.
- `DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `GAP`, 1: idle cycles forced between the end of one frame and the next `start`; ≥1.
- `clk`  input  1  single clock; all logic on posedge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `in_data`  input  WORD  word to transmit.
- `in_valid`  input  1  `in_data` valid.
- `in_ready`  output  1  FIFO can accept; `= (count != DEPTH)`, from registered count only.
- `start`  output  1  one-cycle frame-start pulse to receiver.
- `serial_d`  output  1  serial bit stream, MSB first.
- `busy`  output  1  high from `start` cycle through last GAP cycle.
- `done`  output  1  one-cycle pulse, first cycle after last frame bit.
- `fifo_count`  output  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: `in_valid && in_ready` at a rising edge writes `in_data` at the write pointer. Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, SHIFT, PARITY (macro only), GAP.
- IDLE: `count != 0` at the edge → pop the head into shift register `sr`, clear bit counter, go to START.
- START: `start=1`, `serial_d=0`; go to SHIFT.
- SHIFT: `serial_d = sr[WORD-1]`, shift left each cycle, WORD cycles. Then go to PARITY if enabled, else GAP.
- PARITY: `serial_d` = parity bit, one cycle; go to GAP.
- GAP: `serial_d=0`, `busy=1`; `done=1` in the first GAP cycle only. After GAP cycles, return to IDLE.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- Full: `in_ready=0`; `in_valid` is ignored, and the data is not captured.
- Empty in IDLE: outputs are held at 0, with no frame started.
- Reset, including mid-frame: the frame aborts and the FIFO empties. State returns to IDLE; `start`, `serial_d`, `busy`, `done`, `fifo_count` all 0; `in_ready` 1.

## Timing
- All outputs except `in_ready` are registered. `in_ready` is combinational from registered `count`.
- A word pushed at edge N into an idle, empty block gives `fifo_count=1` in cycle N+1. The pop occurs at edge N+1, and `start=1` is visible in cycle N+2.
- Data bit k (k=0 is the MSB) appears in cycle N+3+k.
- `done` appears in cycle N+3+WORD, or N+4+WORD with parity.
- Frame period with a continuously non-empty FIFO: 1 + WORD (+1 parity) + GAP + 1 (IDLE pop) cycles. At defaults without parity that is 11 cycles.
- `busy` is low only in IDLE.

## Configuration
- `P_TO_S_PARITY_EN` defined: after the WORD data bits, one extra cycle carries even parity, `^data`, so ones in data plus parity is even. `done` is delayed by one cycle.
- Not defined: there is no PARITY state, and the frame is exactly START + WORD bits.

## Test plan
- Single word 0xA5, defaults, no macro, pushed at edge 0:
  - `start` high in cycle 2 only.
  - `serial_d` in cycles 3..10 is 1,0,1,0,0,1,0,1.
  - `done` high in cycle 11.
  - `busy` high in cycles 2..11.
- Burst of 0x01,0x02,0x03,0x04,0x05 with `in_valid` held:
  - `in_ready` drops when `fifo_count=4`.
  - 0x05 is accepted only after the first pop.
  - Five frames go out in order, with `start` pulses 11 cycles apart.
- Push during pop: push at the same edge as an IDLE pop with `fifo_count=2` → `fifo_count` stays 2; data order is preserved.
- With `P_TO_S_PARITY_EN`, words 0x07 and 0x0F:
  - The parity bit is 1 for 0x07 and 0 for 0x0F.
  - For each frame, the parity bit comes in the cycle after the last data bit, and `done` one cycle later.
- Reset asserted mid-SHIFT of 0xFF with 2 words queued:
  - Outputs go to 0 immediately, with `fifo_count=0` and `in_ready=1`.
  - After release, the next push yields a clean frame with the 2-cycle latency.
- GAP=3, two queued words: the second `start` occurs exactly 3 GAP cycles plus 1 IDLE cycle after the first frame's last bit.
